// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: transmit FIFO feeding a start/data/parity/stop
// serialiser with programmable baud divisor, parity mode and stop-bit count.
module uart_tx_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OVER_SAMPL = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DIV_W-1:0]              cfg_div_i,
  input  logic [1:0]                    cfg_parity_i,
  input  logic                          cfg_stop2_i,
  input  logic                          wr_valid_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic                          wr_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          fifo_full_o,
  output logic                          fifo_empty_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OS_W  = $clog2(OVER_SAMPL);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  // Serialiser state
  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              push_c;
  logic              pop_c;
  logic              load_c;
  logic              tick_c;
  logic              bit_end_c;
  logic [DATA_W-1:0] head_c;

  assign push_c    = wr_valid_i && !full_q;
  assign tick_c    = (tick_cnt_q == div_q);
  assign bit_end_c = tick_c && (os_cnt_q == OS_W'(OVER_SAMPL - 1));
  assign head_c    = mem_q[rd_ptr_q];

  // FIFO data array; flushing is done by resetting the pointers and count
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Next-state logic for the serialiser, baud counters and FIFO pointers
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_c     = 1'b0;

    if (state_q != S_IDLE) begin
      tick_cnt_d = tick_c ? '0 : tick_cnt_q + DIV_W'(1);
      if (tick_c) begin
        os_cnt_d = bit_end_c ? '0 : os_cnt_q + OS_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty_q) begin
          load_c = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!empty_q) begin
              load_c = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Frame start: pop head, snapshot config so mid-frame changes are ignored
    if (load_c) begin
      state_d    = S_START;
      shift_d    = head_c;
      div_d      = cfg_div_i;
      par_en_d   = ^cfg_parity_i;
      par_bit_d  = (^head_c) ^ (cfg_parity_i == 2'b10);
      stop2_d    = cfg_stop2_i;
      tick_cnt_d = '0;
      os_cnt_d   = '0;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end
  end

  assign pop_c = load_c;

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      div_q      <= '0;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wr_ready_o   = !full_q;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign tx_done_o    = done_q;
  assign fifo_count_o = count_q;
  assign fifo_full_o  = full_q;
  assign fifo_empty_o = empty_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frame shape, parity/stop options,
// back-to-back frames, FIFO full, mid-frame config change and reset.
module tb_uart_tx_param;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned OVER_SAMPL = 16;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic [DIV_W-1:0]  cfg_div_i = '0;
  logic [1:0]        cfg_parity_i = 2'b00;
  logic              cfg_stop2_i = 1'b0;
  logic              wr_valid_i = 1'b0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              wr_ready_o;
  logic              tx_o;
  logic              busy_o;
  logic              tx_done_o;
  logic [CNT_W-1:0]  fifo_count_o;
  logic              fifo_full_o;
  logic              fifo_empty_o;

  int checks = 0;
  int failures = 0;

  uart_tx_param #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .OVER_SAMPL(OVER_SAMPL), .DIV_W(DIV_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_div_i(cfg_div_i), .cfg_parity_i(cfg_parity_i),
    .cfg_stop2_i(cfg_stop2_i), .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .tx_o(tx_o), .busy_o(busy_o), .tx_done_o(tx_done_o),
    .fifo_count_o(fifo_count_o), .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o)
  );

  always #5 clk = ~clk;

  // Sample a whole frame starting at its first start-bit sample; ends on the
  // sample where tx_done_o must be high (first sample of any following frame).
  task automatic run_frame(input string name, input logic [15:0] bits, input int nbits,
                           input int blen, input logic more);
    logic bad;
    logic seen_tx;
    for (int b = 0; b < nbits; b++) begin
      bad = 1'b0;
      seen_tx = bits[b];
      for (int s = 0; s < blen; s++) begin
        if (b != 0 || s != 0) @(negedge clk);
        if (tx_o !== bits[b] || busy_o !== 1'b1 || (tx_done_o !== 1'b0 && !(b == 0 && s == 0))) begin
          bad = 1'b1;
          seen_tx = tx_o;
        end
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s bit%0d: got tx=%0b busy=%0b done=%0b, need tx=%0b busy=1 done=0 for %0d clocks",
                 name, b, seen_tx, busy_o, tx_done_o, bits[b], blen);
      end
    end
    @(negedge clk);
    checks++;
    if (tx_done_o !== 1'b1) begin
      failures++;
      $display("FAIL %s done_pulse: got %0b need 1 after %0d clocks", name, tx_done_o, nbits * blen);
    end
    checks++;
    if (tx_o !== !more || busy_o !== more) begin
      failures++;
      $display("FAIL %s after_frame: got tx=%0b busy=%0b need tx=%0b busy=%0b",
               name, tx_o, busy_o, !more, more);
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_line: got tx=%0b busy=%0b done=%0b need 1 0 0", tx_o, busy_o, tx_done_o);
    end
    checks++;
    if (wr_ready_o !== 1'b1 || fifo_full_o !== 1'b0 || fifo_empty_o !== 1'b1 || fifo_count_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_fifo: got ready=%0b full=%0b empty=%0b count=%0d need 1 0 1 0",
               wr_ready_o, fifo_full_o, fifo_empty_o, fifo_count_o);
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got tx=%0b busy=%0b need 1 0", tx_o, busy_o);
    end
  endtask

  task automatic test_basic;
    cfg_div_i = 16'd0; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
    @(negedge clk); wr_valid_i = 1'b1; wr_data_i = 8'hA5;
    @(negedge clk); wr_valid_i = 1'b0;
    checks++;
    if (fifo_count_o !== 3'd1 || busy_o !== 1'b0 || tx_o !== 1'b1 || fifo_empty_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency: got count=%0d busy=%0b tx=%0b empty=%0b need 1 0 1 0",
               fifo_count_o, busy_o, tx_o, fifo_empty_o);
    end
    @(negedge clk);
    run_frame("basic", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16, 1'b0);
    @(negedge clk);
    checks++;
    if (tx_done_o !== 1'b0 || busy_o !== 1'b0 || fifo_empty_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_idle: got done=%0b busy=%0b empty=%0b need 0 0 1", tx_done_o, busy_o, fifo_empty_o);
    end
  endtask

  task automatic test_parity;
    cfg_parity_i = 2'b01; cfg_stop2_i = 1'b0;
    @(negedge clk); wr_valid_i = 1'b1; wr_data_i = 8'h07;
    @(negedge clk); wr_valid_i = 1'b0;
    @(negedge clk);
    run_frame("par_even", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 16, 1'b0);
    // odd parity, two stop bits, two frames so the 32-clock high gap is visible
    cfg_parity_i = 2'b10; cfg_stop2_i = 1'b1;
    @(negedge clk); wr_valid_i = 1'b1; wr_data_i = 8'h07;
    @(negedge clk);
    @(negedge clk); wr_valid_i = 1'b0;
    run_frame("par_odd_stop2_a", {4'b0, 2'b11, 1'b0, 8'h07, 1'b0}, 12, 16, 1'b1);
    run_frame("par_odd_stop2_b", {4'b0, 2'b11, 1'b0, 8'h07, 1'b0}, 12, 16, 1'b0);
    cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    cfg_div_i = 16'd0; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
    @(negedge clk); wr_valid_i = 1'b1; wr_data_i = 8'h11;
    @(negedge clk); wr_data_i = 8'h22;
    @(negedge clk); wr_data_i = 8'h33;
    fork
      begin @(negedge clk); wr_valid_i = 1'b0; end
    join_none
    run_frame("b2b_0x11", {6'b0, 1'b1, 8'h11, 1'b0}, 10, 16, 1'b1);
    run_frame("b2b_0x22", {6'b0, 1'b1, 8'h22, 1'b0}, 10, 16, 1'b1);
    run_frame("b2b_0x33", {6'b0, 1'b1, 8'h33, 1'b0}, 10, 16, 1'b0);
  endtask

  task automatic test_fifo_full;
    int waits;
    cfg_div_i = 16'd100; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
    @(negedge clk); wr_valid_i = 1'b1; wr_data_i = 8'hE0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (fifo_count_o !== 3'd1 || busy_o !== 1'b1 || tx_o !== 1'b0) begin
          failures++;
          $display("FAIL full_first_pop: got count=%0d busy=%0b tx=%0b need 1 1 0", fifo_count_o, busy_o, tx_o);
        end
      end
      wr_data_i = 8'hE0 + 8'(i);
    end
    wr_valid_i = 1'b0;
    checks++;
    if (fifo_count_o !== 3'd4 || fifo_full_o !== 1'b1 || wr_ready_o !== 1'b0 || fifo_empty_o !== 1'b0) begin
      failures++;
      $display("FAIL full_state: got count=%0d full=%0b ready=%0b empty=%0b need 4 1 0 0",
               fifo_count_o, fifo_full_o, wr_ready_o, fifo_empty_o);
    end
    waits = 0;
    while (tx_done_o !== 1'b1 && waits < 20000) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (waits != 16156) begin
      failures++;
      $display("FAIL full_frame_len: got done after %0d clocks need 16156", waits);
    end
    checks++;
    if (fifo_count_o !== 3'd3 || wr_ready_o !== 1'b1 || fifo_full_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL full_drain: got count=%0d ready=%0b full=%0b busy=%0b need 3 1 0 1",
               fifo_count_o, wr_ready_o, fifo_full_o, busy_o);
    end
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cfg_change;
    cfg_div_i = 16'd0; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
    @(negedge clk); wr_valid_i = 1'b1; wr_data_i = 8'h5A;
    @(negedge clk); wr_data_i = 8'hC3;
    @(negedge clk); wr_valid_i = 1'b0;
    fork
      begin repeat (30) @(negedge clk); cfg_parity_i = 2'b01; cfg_div_i = 16'd3; end
    join_none
    run_frame("cfg_frame1", {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 16, 1'b1);
    run_frame("cfg_frame2", {5'b0, 1'b1, 1'b0, 8'hC3, 1'b0}, 11, 64, 1'b0);
    cfg_div_i = 16'd0; cfg_parity_i = 2'b00;
  endtask

  task automatic test_reset_mid_frame;
    logic bad;
    cfg_div_i = 16'd0; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
    @(negedge clk); wr_valid_i = 1'b1; wr_data_i = 8'h3C;
    @(negedge clk); wr_data_i = 8'h4D;
    @(negedge clk); wr_data_i = 8'h5E;
    @(negedge clk); wr_valid_i = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (fifo_count_o !== 3'd2 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got count=%0d busy=%0b need 2 1", fifo_count_o, busy_o);
    end
    rst_ni = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0 || fifo_empty_o !== 1'b1 || wr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_flush: got tx=%0b busy=%0b count=%0d empty=%0b ready=%0b need 1 0 0 1 1",
               tx_o, busy_o, fifo_count_o, fifo_empty_o, wr_ready_o);
    end
    rst_ni = 1'b1;
    bad = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || tx_done_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rst_mid_quiet: line activity after reset release, need tx=1 busy=0 done=0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_fifo_full();
    test_cfg_change();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
